muldiv_seq: RTL

Iterative RV32M multiply/divide sequencer in the EX stage, beside the main ALU. On a start request it runs a radix-2 shift-add or restoring-divide loop over 32 cycles and holds the pipeline with a stall signal. It then delivers the 32-bit result with a one-cycle done pulse and releases the stall. It owns its own adder and shift registers, so the main ALU stays free for the single-cycle ops.

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake/bus bundle between the EX-stage pipeline control and the
// iterative RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] Result;

   modport master (
      output start, funct3, A, B, flush,
      input  stall, busy, done, Result
   );

   modport slave (
      input  start, funct3, A, B, flush,
      output stall, busy, done, Result
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fixed up at the end.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_seq_if.slave  bus
);
   localparam int W2 = 2 * XLEN;

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      f3_q, f3_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [5:0]      cnt_q, cnt_d;
   logic            sign_q, sign_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            busy_q, busy_d;

   logic            is_div, signed_a, signed_b, neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum, rem_sh, div_diff;
   logic            q_ok;
   logic [W2-1:0]   mul_acc, div_acc, prod;
   logic [XLEN-1:0] quo, rem;

   // Operand interpretation and magnitude conversion for PREP.
   always_comb begin
      is_div   = f3_q[2];
      signed_a = (f3_q == 3'd1) || (f3_q == 3'd2) || (f3_q == 3'd4) || (f3_q == 3'd6);
      signed_b = (f3_q == 3'd1) || (f3_q == 3'd4) || (f3_q == 3'd6);
      neg_a    = signed_a & a_q[XLEN-1];
      neg_b    = signed_b & b_q[XLEN-1];
      mag_a    = neg_a ? (~a_q + 1'b1) : a_q;
      mag_b    = neg_b ? (~b_q + 1'b1) : b_q;
   end

   // One iteration of each loop. Multiply keeps the multiplicand in a_q and
   // shifts the multiplier out of b_q; divide shifts the dividend out of a_q.
   always_comb begin
      mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, (b_q[0] ? a_q : {XLEN{1'b0}})};
      mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
      rem_sh   = {acc_q[W2-1:XLEN], a_q[XLEN-1]};
      div_diff = rem_sh - {1'b0, b_q};
      q_ok     = ~div_diff[XLEN];
      div_acc  = {(q_ok ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_ok};
   end

   always_comb begin
      prod = sign_q ? (~acc_q + 1'b1) : acc_q;
      quo  = sign_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem  = sign_q ? (~acc_q[W2-1:XLEN] + 1'b1) : acc_q[W2-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               f3_d    = bus.funct3;
               a_d     = bus.A;
               b_d     = bus.B;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            a_d    = mag_a;
            b_d    = mag_b;
            acc_d  = '0;
            cnt_d  = 6'(XLEN);
            // Remainder follows the dividend; product and quotient follow both.
            sign_d = (is_div && f3_q[1]) ? neg_a : (neg_a ^ neg_b);
            if (is_div && (b_q == '0)) begin
               result_d = f3_q[1] ? a_q : {XLEN{1'b1}};
               state_d  = S_DONE;
            end else begin
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q - 6'd1;
            if (is_div) begin
               acc_d = div_acc;
               a_d   = a_q << 1;
            end else begin
               acc_d = mul_acc;
               b_d   = b_q >> 1;
            end
            if (cnt_q == 6'd1) state_d = S_FIX;
         end
         S_FIX: begin
            case (f3_q)
               3'd0:             result_d = prod[XLEN-1:0];
               3'd1, 3'd2, 3'd3: result_d = prod[W2-1:XLEN];
               3'd4, 3'd5:       result_d = quo;
               default:          result_d = rem;
            endcase
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort wins everywhere and must not disturb the last delivered result.
      if (bus.flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         f3_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   // Stall drops in DONE so the dependent instruction advances with Result.
   assign bus.stall  = rst_n & ((bus.start & (state_q == S_IDLE) & ~bus.flush) |
                                (state_q == S_PREP) | (state_q == S_CALC) | (state_q == S_FIX));
   assign bus.busy   = busy_q;
   assign bus.done   = (state_q == S_DONE);
   assign bus.Result = result_q;
endmodule
